// File: rtl/instr_encoder_loader_if.sv
// Instruction loader bus: the field handshake (valid/ready plus decoded
// instruction fields) and the instruction-memory write port.
//   master: supplies fields, observes the memory write port (bench/host side)
//   slave : accepts fields, drives the memory write port (loader side)
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [3:0]        in_rd;
  logic [3:0]        in_rs;
  logic [3:0]        in_rt;
  logic [15:0]       in_imm;
  logic [2:0]        in_cond;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_wr;

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, in_cond,
    input  in_ready, mem_addr, mem_data, mem_wr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, in_cond,
    output in_ready, mem_addr, mem_data, mem_wr
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// WISC-S25 program loader: range-checks instruction fields, packs them into
// 16-bit instruction words and writes them sequentially to instruction memory.
// A session starts on a start pulse and ends on HLT (done) or on the first
// illegal field / address overflow (err).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, base_addr  session start pulse and first write address
//   bus (slave)       field handshake in, memory write port out
//   busy, done, err   session status; done/err sticky until start or rst
//   err_code          01 misaligned, 10 out of range, 11 address overflow
//   count             words written in the current session
//
// state  | meaning
// IDLE   | no session since reset
// ACCEPT | in_ready high, waiting for a field set
// WRITE  | one-cycle memory write of the encoded word
// DONE   | HLT written, session finished
// ERR    | session aborted, err_code holds the reason
module instr_encoder_loader #(
  parameter int ADDR_W = 16,
  parameter int INC    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  instr_encoder_loader_if.slave    bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [15:0]              count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [15:0]       HLT_WORD  = 16'hF000;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [15:0]       data_q, data_n;
  logic [15:0]       count_q, count_n;
  logic [1:0]        code_q, code_n;
  logic              ready_q, wr_q, busy_q, done_q, err_q;

  logic [15:0]       enc_word;
  logic [1:0]        enc_code;

  // Encoder and range check. A value fits a signed n-bit field when all bits
  // above bit n-2 are identical (all zeros or all ones).
  always_comb begin
    enc_word = 16'h0000;
    enc_code = 2'b00;
    case (bus.in_op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        enc_word = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_rt};
      end
      4'h4, 4'h5, 4'h6: begin
        enc_word = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_imm[3:0]};
        if (bus.in_imm[15:4] != 12'h000) enc_code = 2'b10;
      end
      4'h8, 4'h9: begin
        // byte offset, stored as word offset; misalignment wins over range
        enc_word = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_imm[4:1]};
        if (bus.in_imm[0]) enc_code = 2'b01;
        else if (bus.in_imm[15:4] != 12'h000 && bus.in_imm[15:4] != 12'hFFF)
          enc_code = 2'b10;
      end
      4'hA, 4'hB: begin
        enc_word = {bus.in_op, bus.in_rd, bus.in_imm[7:0]};
        if (bus.in_imm[15:8] != 8'h00) enc_code = 2'b10;
      end
      4'hC: begin
        enc_word = {bus.in_op, bus.in_cond, bus.in_imm[8:0]};
        if (bus.in_imm[15:8] != 8'h00 && bus.in_imm[15:8] != 8'hFF)
          enc_code = 2'b10;
      end
      4'hD: begin
        enc_word = {bus.in_op, bus.in_cond, 1'b0, bus.in_rs, 4'h0};
      end
      4'hE: begin
        enc_word = {bus.in_op, bus.in_rd, 8'h00};
      end
      default: begin
        enc_word = HLT_WORD;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    data_n  = data_q;
    count_n = count_q;
    code_n  = code_q;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          addr_n  = {base_addr[ADDR_W-1:1], 1'b0};
          count_n = 16'd0;
          code_n  = 2'b00;
          state_n = ACCEPT;
        end
      end
      ACCEPT: begin
        if (bus.in_valid && ready_q) begin
          if (enc_code == 2'b00) begin
            data_n  = enc_word;
            state_n = WRITE;
          end else begin
            code_n  = enc_code;
            state_n = ERR;
          end
        end
      end
      WRITE: begin
        addr_n  = addr_q + ADDR_W'(INC);
        count_n = count_q + 16'd1;
        if (data_q == HLT_WORD) begin
          state_n = DONE;
        end else if (addr_q == LAST_ADDR) begin
          code_n  = 2'b11;
          state_n = ERR;
        end else begin
          state_n = ACCEPT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      count_q <= 16'd0;
      code_q  <= 2'b00;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      count_q <= count_n;
      code_q  <= code_n;
      ready_q <= (state_n == ACCEPT);
      wr_q    <= (state_n == WRITE);
      busy_q  <= (state_n == ACCEPT) || (state_n == WRITE);
      done_q  <= (state_n == DONE);
      err_q   <= (state_n == ERR);
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign bus.mem_wr   = wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = code_q;
  assign count        = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] count;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder_loader_if #(.ADDR_W(16)) bus ();

  instr_encoder_loader #(.ADDR_W(16), .INC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [3:0] rt, input logic [15:0] imm, input logic [2:0] cond);
    bus.in_op   = op;
    bus.in_rd   = rd;
    bus.in_rs   = rs;
    bus.in_rt   = rt;
    bus.in_imm  = imm;
    bus.in_cond = cond;
  endtask

  task automatic start_session(input logic [15:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for in_ready, presents one field set for one accept edge.
  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [15:0] imm, input logic [2:0] cond);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("in_ready_before_send", bus.in_ready, 1);
    set_fields(op, rd, rs, rt, imm, cond);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [15:0] addr, input logic [15:0] data);
    check({tag, "_wr"}, bus.mem_wr, 1);
    check({tag, "_addr"}, bus.mem_addr, addr);
    check({tag, "_data"}, bus.mem_data, data);
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code, input logic [15:0] cnt);
    check({tag, "_err"}, err, 1);
    check({tag, "_code"}, err_code, code);
    check({tag, "_nowr"}, bus.mem_wr, 0);
    check({tag, "_count"}, count, cnt);
    check({tag, "_busy"}, busy, 0);
  endtask

  logic [15:0] hlt_exp [4] = '{16'h0123, 16'hE200, 16'hDA90, 16'hF000};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = 16'h0000;
    bus.in_valid = 1'b0;
    set_fields(4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 3'd0);
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_data", bus.mem_data, 0);
    check("rst_count", count, 0);
    rst = 1'b0;
    tick();

    // Basic R-type, odd base forced even
    start_session(16'h0101);
    check("s1_busy", busy, 1);
    check("s1_addr", bus.mem_addr, 16'h0100);
    send(4'h0, 4'h1, 4'h2, 4'h3, 16'hBEEF, 3'd6);
    expect_write("add", 16'h0100, 16'h0123);
    check("add_rdy_low", bus.in_ready, 0);
    tick();
    check("add_next_addr", bus.mem_addr, 16'h0102);
    check("add_count", count, 1);
    check("add_gap_wr", bus.mem_wr, 0);

    // LW negative offset, then misaligned SW
    send(4'h8, 4'h4, 4'h5, 4'hA, 16'hFFFC, 3'd0);
    expect_write("lw_neg", 16'h0102, 16'h845E);
    tick();
    send(4'h9, 4'h4, 4'h5, 4'h0, 16'h0003, 3'd0);
    expect_err("sw_mis", 2'b01, 16'd2);
    tick();
    check("sw_mis_still_nowr", bus.mem_wr, 0);

    // Branch, immediates and range boundaries
    start_session(16'h0200);
    check("s2_err_clr", err, 0);
    check("s2_code_clr", err_code, 0);
    check("s2_count_clr", count, 0);
    send(4'hC, 4'h9, 4'h1, 4'h2, 16'hFFFF, 3'd3);
    expect_write("b_neg", 16'h0200, 16'hC7FF);
    tick();
    send(4'hA, 4'h7, 4'hC, 4'hD, 16'h00AB, 3'd1);
    expect_write("llb", 16'h0202, 16'hA7AB);
    tick();
    send(4'h4, 4'h1, 4'h2, 4'h9, 16'h000F, 3'd0);
    expect_write("sll15", 16'h0204, 16'h412F);
    tick();
    send(4'h8, 4'h0, 4'h0, 4'h0, 16'h000E, 3'd0);
    expect_write("lw14", 16'h0206, 16'h8007);
    tick();
    send(4'h9, 4'h1, 4'h2, 4'h0, 16'hFFF0, 3'd0);
    expect_write("sw_m16", 16'h0208, 16'h9128);
    tick();
    check("s2_count", count, 5);
    send(4'hC, 4'h0, 4'h0, 4'h0, 16'h0100, 3'd3);
    expect_err("b_256", 2'b10, 16'd5);

    start_session(16'h0300);
    send(4'h4, 4'h1, 4'h2, 4'h0, 16'h0010, 3'd0);
    expect_err("sll16", 2'b10, 16'd0);
    start_session(16'h0300);
    send(4'h8, 4'h1, 4'h2, 4'h0, 16'h0010, 3'd0);
    expect_err("lw16", 2'b10, 16'd0);
    start_session(16'h0300);
    send(4'h9, 4'h1, 4'h2, 4'h0, 16'hFFEF, 3'd0);
    expect_err("sw_m17", 2'b01, 16'd0);

    // Full session to HLT with in_valid held high; new fields appear during WRITE
    start_session(16'h0010);
    set_fields(4'h0, 4'h1, 4'h2, 4'h3, 16'h5555, 3'd7);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_write("full", 16'h0010 + 16'(2 * i), hlt_exp[i]);
      if (i == 0) set_fields(4'hE, 4'h2, 4'hF, 4'hF, 16'hFFFF, 3'd7);
      if (i == 1) set_fields(4'hD, 4'h7, 4'h9, 4'h6, 16'h1234, 3'd5);
      if (i == 2) set_fields(4'hF, 4'h3, 4'h4, 4'h5, 16'h0007, 3'd2);
      tick();
      check("full_gap_wr", bus.mem_wr, 0);
    end
    check("hlt_done", done, 1);
    check("hlt_count", count, 4);
    check("hlt_in_ready", bus.in_ready, 0);
    check("hlt_busy", busy, 0);
    repeat (3) tick();
    check("hlt_ignored_wr", bus.mem_wr, 0);
    check("hlt_ignored_count", count, 4);
    check("hlt_done_sticky", done, 1);
    bus.in_valid = 1'b0;

    // Restart after DONE; start during ACCEPT ignored
    start_session(16'h0300);
    check("rs_done_clr", done, 0);
    check("rs_count_clr", count, 0);
    check("rs_addr", bus.mem_addr, 16'h0300);
    start_session(16'h0500);
    check("acc_start_ignored", bus.mem_addr, 16'h0300);
    check("acc_start_ready", bus.in_ready, 1);
    send(4'h1, 4'h4, 4'h5, 4'h6, 16'h0000, 3'd0);
    expect_write("pre_rst", 16'h0300, 16'h1456);

    // Asynchronous reset in WRITE
    #2;
    rst = 1'b1;
    #1;
    check("arst_mem_wr", bus.mem_wr, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", bus.in_ready, 0);
    check("arst_addr", bus.mem_addr, 0);
    check("arst_data", bus.mem_data, 0);
    #1;
    rst = 1'b0;
    tick();
    check("arst_idle_wr", bus.mem_wr, 0);

    // Address overflow
    start_session(16'hFFFF);
    send(4'h0, 4'h1, 4'h2, 4'h3, 16'h0000, 3'd0);
    expect_write("ovf", 16'hFFFE, 16'h0123);
    tick();
    expect_err("ovf", 2'b11, 16'd1);
    check("ovf_wrap", bus.mem_addr, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
